// File: rtl/wb8_arbiter2.sv
// Two-master round-robin arbiter in front of a shared 8-bit, 4K-entry
// Wishbone-style RAM, with a wait-state timeout that forces a release.
module wb8_arbiter2 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [11:0] M0_ADR_I,
    input  logic [7:0]  M0_DAT_I,
    output logic [7:0]  M0_DAT_O,
    output logic        M0_ACK_O,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [11:0] M1_ADR_I,
    input  logic [7:0]  M1_DAT_I,
    output logic [7:0]  M1_DAT_O,
    output logic        M1_ACK_O,
    output logic        S_STB_O,
    output logic        S_WE_O,
    output logic [11:0] S_ADR_O,
    output logic [7:0]  S_DAT_O,
    input  logic [7:0]  S_DAT_I,
    input  logic        S_ACK_I,
    output logic [1:0]  GNT_O,
    output logic        ERR_O
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        busy;
    logic        sel_stb;
    logic        sel_we;
    logic [11:0] sel_adr;
    logic [7:0]  sel_dat;
    logic        fwd_ack;

    assign busy = (state_q == BUSY);

    always_comb begin
        sel_stb = M0_STB_I;
        sel_we  = M0_WE_I;
        sel_adr = M0_ADR_I;
        sel_dat = M0_DAT_I;
        if (gnt_q) begin
            sel_stb = M1_STB_I;
            sel_we  = M1_WE_I;
            sel_adr = M1_ADR_I;
            sel_dat = M1_DAT_I;
        end
    end

    assign fwd_ack = busy & sel_stb & S_ACK_I;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                unique case (1'b1)
                    (M0_STB_I && M1_STB_I): begin
                        gnt_d   = ~last_q;
                        state_d = BUSY;
                    end
                    (M0_STB_I && !M1_STB_I): begin
                        gnt_d   = 1'b0;
                        state_d = BUSY;
                    end
                    (!M0_STB_I && M1_STB_I): begin
                        gnt_d   = 1'b1;
                        state_d = BUSY;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            BUSY: begin
                // Ack and abort both end the grant; timeout only if neither.
                if (!sel_stb || S_ACK_I) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Strobe is withheld in the ack cycle so the RAM never acks twice.
    assign S_STB_O  = busy & sel_stb & ~S_ACK_I;
    assign S_WE_O   = busy & sel_we;
    assign S_ADR_O  = busy ? sel_adr : 12'h000;
    assign S_DAT_O  = busy ? sel_dat : 8'h00;

    assign M0_ACK_O = fwd_ack & ~gnt_q;
    assign M1_ACK_O = fwd_ack & gnt_q;
    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;

    assign GNT_O    = busy ? {gnt_q, ~gnt_q} : 2'b00;
    assign ERR_O    = err_q;

endmodule
